vehicle_sensor_conditioner: RTL and testbench

VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

---
 rtl/vehicle_sensor_conditioner.sv | 175 +++++++++++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_sensor_conditioner.sv
// Vehicle sensor conditioner: synchronizes and debounces the arrival and
// departure loop sensors, keeps a saturating count of waiting vehicles, and
// drives the car-present request X with a minimum hold time and stuck-sensor
// fault handling.
module vehicle_sensor_conditioner #(
  parameter logic [19:0] DEB_CYCLES   = 20'd1000,
  parameter logic [28:0] HOLD_CYCLES  = 29'd100_000_000,
  parameter logic [28:0] STUCK_CYCLES = 29'd500_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       arr_raw,
  input  logic       dep_raw,
  output logic       X,
  output logic [3:0] car_count,
  output logic       stuck_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  state_t      nxt_state;

  logic [1:0]  arr_sync;
  logic [1:0]  dep_sync;
  logic        arr_filt;
  logic        dep_filt;
  logic [19:0] arr_deb;
  logic [19:0] dep_deb;
  logic        arr_filt_d;
  logic        dep_filt_d;
  logic        arr_arm;
  logic        dep_arm;
  logic [1:0]  sync_vld;
  logic        arr_evt;
  logic        dep_evt;
  logic [28:0] stuck_cnt;
  logic        stuck_hit;
  logic [28:0] hold_cnt;

  // Two-flop synchronizers for both raw loop sensors.
  always_ff @(posedge clock) begin
    if (rst) begin
      arr_sync <= '0;
      dep_sync <= '0;
    end else begin
      arr_sync <= {arr_sync[0], arr_raw};
      dep_sync <= {dep_sync[0], dep_raw};
    end
  end

  // Arrival debounce: filtered value follows only after DEB_CYCLES of disagreement.
  always_ff @(posedge clock) begin
    if (rst) begin
      arr_filt <= 1'b0;
      arr_deb  <= '0;
    end else if (arr_sync[1] == arr_filt) begin
      arr_deb <= '0;
    end else if (arr_deb == DEB_CYCLES - 20'd1) begin
      arr_filt <= arr_sync[1];
      arr_deb  <= '0;
    end else begin
      arr_deb <= arr_deb + 20'd1;
    end
  end

  // Departure debounce, identical to the arrival path.
  always_ff @(posedge clock) begin
    if (rst) begin
      dep_filt <= 1'b0;
      dep_deb  <= '0;
    end else if (dep_sync[1] == dep_filt) begin
      dep_deb <= '0;
    end else if (dep_deb == DEB_CYCLES - 20'd1) begin
      dep_filt <= dep_sync[1];
      dep_deb  <= '0;
    end else begin
      dep_deb <= dep_deb + 20'd1;
    end
  end

  // Edge-detector history plus arming: a sensor only produces events once it
  // has been seen low after reset, so a level already high at reset release
  // never counts as a vehicle. sync_vld marks when the synchronizer output is
  // a real sample rather than its reset value.
  always_ff @(posedge clock) begin
    if (rst) begin
      arr_filt_d <= 1'b0;
      dep_filt_d <= 1'b0;
      arr_arm    <= 1'b0;
      dep_arm    <= 1'b0;
      sync_vld   <= '0;
    end else begin
      arr_filt_d <= arr_filt;
      dep_filt_d <= dep_filt;
      sync_vld   <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !arr_sync[1] && !arr_filt) arr_arm <= 1'b1;
      if (sync_vld[1] && !dep_sync[1] && !dep_filt) dep_arm <= 1'b1;
    end
  end

  assign arr_evt = arr_filt & ~arr_filt_d & arr_arm;
  assign dep_evt = dep_filt & ~dep_filt_d & dep_arm;

  // Stuck detector: counts cycles of filtered arrival high, saturating at the limit.
  always_ff @(posedge clock) begin
    if (rst) begin
      stuck_cnt <= '0;
    end else if (!arr_filt) begin
      stuck_cnt <= '0;
    end else if (stuck_cnt != STUCK_CYCLES) begin
      stuck_cnt <= stuck_cnt + 29'd1;
    end
  end

  // Qualified with the live level so a saturated count never outlives the release.
  assign stuck_hit = arr_filt && (stuck_cnt == STUCK_CYCLES);

  // Next-state logic; a stuck sensor overrides every other transition.
  always_comb begin
    nxt_state = state;
    if (stuck_hit) begin
      nxt_state = FAULT;
    end else begin
      case (state)
        IDLE:    if (car_count != 4'd0) nxt_state = REQ;
        REQ:     if (car_count == 4'd0 && hold_cnt == 29'd0) nxt_state = IDLE;
        FAULT:   if (!arr_filt) nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // State register, registered output decodes and the minimum-hold timer.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      X           <= 1'b0;
      stuck_fault <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= nxt_state;
      X           <= (nxt_state != IDLE);
      stuck_fault <= (nxt_state == FAULT);
      if (state == IDLE && nxt_state == REQ) begin
        hold_cnt <= HOLD_CYCLES;
      end else if (state == REQ) begin
        if (hold_cnt != 29'd0) hold_cnt <= hold_cnt - 29'd1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // Waiting-vehicle counter; events are ignored in FAULT and the count is
  // discarded when the fault clears.
  always_ff @(posedge clock) begin
    if (rst) begin
      car_count <= '0;
    end else if (state == FAULT) begin
      if (nxt_state == IDLE) car_count <= '0;
    end else begin
      case ({dep_evt, arr_evt})
        2'b01:   if (car_count != 4'd15) car_count <= car_count + 4'd1;
        2'b10:   if (car_count != 4'd0)  car_count <= car_count - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed testbench for vehicle_sensor_conditioner with DEB_CYCLES=4,
// HOLD_CYCLES=10, STUCK_CYCLES=50. Timelines are indexed by clock edge:
// in loop iteration c the raw inputs are applied before edge Ec and the
// outputs are sampled 1 time unit after Ec.
module tb_vehicle_sensor_conditioner;

  logic       clock = 1'b0;
  logic       rst;
  logic       arr_raw;
  logic       dep_raw;
  logic       X;
  logic [3:0] car_count;
  logic       stuck_fault;

  int errors = 0;
  int checks = 0;

  vehicle_sensor_conditioner #(
    .DEB_CYCLES  (20'd4),
    .HOLD_CYCLES (29'd10),
    .STUCK_CYCLES(29'd50)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .arr_raw    (arr_raw),
    .dep_raw    (dep_raw),
    .X          (X),
    .car_count  (car_count),
    .stuck_fault(stuck_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reset pulse, check cleared outputs, then idle so both sensors arm.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_X", X, 0);
    check("rst_count", car_count, 0);
    check("rst_stuck", stuck_fault, 0);
    rst = 1'b0;
    repeat (4) tick();
  endtask

  // 6-cycle raw pulse followed by 6 quiet cycles; count settles before return.
  task automatic pulse(input logic a, input logic d);
    arr_raw = a;
    dep_raw = d;
    repeat (6) tick();
    arr_raw = 1'b0;
    dep_raw = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst     = 1'b1;
    arr_raw = 1'b0;
    dep_raw = 1'b0;
    tick();
    tick();
    do_reset();

    // 3-cycle glitch is rejected.
    arr_raw = 1'b1;
    repeat (3) tick();
    arr_raw = 1'b0;
    repeat (10) tick();
    check("glitch_count", car_count, 0);
    check("glitch_X", X, 0);

    // 6-cycle pulse: count 1 at E7, X one cycle later.
    for (int c = 1; c <= 8; c++) begin
      arr_raw = (c <= 6);
      tick();
      if (c == 6) check("arr_pre_count", car_count, 0);
      if (c == 7) begin
        check("arr_count1", car_count, 1);
        check("arr_X_late", X, 0);
      end
      if (c == 8) check("arr_X_high", X, 1);
    end
    arr_raw = 1'b0;

    // Arrival then quick departure: X held until hold timer expires.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      arr_raw = (c <= 6);
      dep_raw = (c >= 3 && c <= 8);
      tick();
      if (c == 9)  check("hold_count0", car_count, 0);
      if (c == 18) check("hold_X_last", X, 1);
      if (c == 19) check("hold_X_drop", X, 0);
    end

    // Arrival while in REQ does not reload the hold timer.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      arr_raw = (c <= 6) || (c >= 11 && c <= 16);
      dep_raw = (c >= 9 && c <= 14) || (c >= 19 && c <= 24);
      tick();
      if (c == 15) check("noreload_cnt0", car_count, 0);
      if (c == 16) check("noreload_Xhold", X, 1);
      if (c == 17) check("noreload_cnt1", car_count, 1);
      if (c == 25) begin
        check("noreload_cnt_end", car_count, 0);
        check("noreload_X_last", X, 1);
      end
      if (c == 26) check("noreload_X_drop", X, 0);
    end
    arr_raw = 1'b0;
    dep_raw = 1'b0;

    // Three arrivals then three departures.
    do_reset();
    repeat (3) pulse(1'b1, 1'b0);
    check("three_arr_count", car_count, 3);
    check("three_arr_X", X, 1);
    repeat (2) pulse(1'b0, 1'b1);
    check("two_dep_count", car_count, 1);
    dep_raw = 1'b1;
    repeat (6) tick();
    dep_raw = 1'b0;
    tick();
    check("last_dep_count", car_count, 0);
    check("last_dep_X", X, 1);
    tick();
    check("last_dep_X_drop", X, 0);
    repeat (6) tick();

    // Saturation at 15 and no underflow below 0.
    do_reset();
    repeat (15) pulse(1'b1, 1'b0);
    check("count15", car_count, 15);
    pulse(1'b1, 1'b0);
    check("count_sat", car_count, 15);
    repeat (15) pulse(1'b0, 1'b1);
    check("count_empty", car_count, 0);
    pulse(1'b0, 1'b1);
    check("count_underflow", car_count, 0);

    // Simultaneous arrival and departure leave the count unchanged.
    do_reset();
    pulse(1'b1, 1'b0);
    check("both_pre", car_count, 1);
    pulse(1'b1, 1'b1);
    check("both_same", car_count, 1);

    // Stuck arrival: FAULT at E57, departure ignored, release clears the count.
    do_reset();
    for (int c = 1; c <= 75; c++) begin
      arr_raw = (c <= 60);
      dep_raw = (c >= 57 && c <= 62);
      tick();
      if (c == 56) begin
        check("stuck_pre", stuck_fault, 0);
        check("stuck_pre_X", X, 1);
      end
      if (c == 57) begin
        check("stuck_set", stuck_fault, 1);
        check("stuck_X", X, 1);
      end
      if (c == 66) begin
        check("stuck_hold", stuck_fault, 1);
        check("stuck_ignore_dep", car_count, 1);
      end
      if (c == 67) begin
        check("stuck_clear", stuck_fault, 0);
        check("stuck_clear_X", X, 0);
        check("stuck_clear_count", car_count, 0);
      end
      if (c == 75) check("stuck_idle_X", X, 0);
    end
    arr_raw = 1'b0;
    dep_raw = 1'b0;

    // Reset while in REQ with two cars, arrival sensor left high.
    do_reset();
    repeat (2) pulse(1'b1, 1'b0);
    check("midrst_pre_count", car_count, 2);
    check("midrst_pre_X", X, 1);
    arr_raw = 1'b1;
    rst = 1'b1;
    tick();
    check("midrst_X", X, 0);
    check("midrst_count", car_count, 0);
    check("midrst_stuck", stuck_fault, 0);
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_evt", car_count, 0);
    check("midrst_no_req", X, 0);
    arr_raw = 1'b0;
    repeat (10) tick();
    pulse(1'b1, 1'b0);
    check("midrst_resume", car_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
